// File: rtl/priority_encoder_seq_pkg.sv
// Shared codec definitions: default request width, code width and the
// sequential encoder state encoding.
package priority_encoder_seq_pkg;

    localparam int PE_WIDTH = 8;
    localparam int PE_CW    = $clog2(PE_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } pe_state_e;

endpackage

// File: rtl/priority_encoder_seq_prio_enc.sv
// Combinational MSB-first priority encoder: index of the highest set bit,
// plus a flag for an all-zero vector (code is 0 in that case).
module prio_enc #(
    parameter  int WIDTH = priority_encoder_seq_pkg::PE_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [CW-1:0]    o_code,
    output logic             o_none
);

    // Ascending scan: later (higher) set bits overwrite earlier ones.
    always_comb begin
        o_code = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) o_code = CW'(i);
        end
    end

    assign o_none = ~|i_vec;

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: captures a request vector, then emits one
// beat per set bit (MSB first), or a single "none" beat for a zero vector.
module priority_encoder_seq
    import priority_encoder_seq_pkg::*;
#(
    parameter  int WIDTH = PE_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_code,
    output logic             out_none,
    output logic             out_last
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    pe_state_e        r_state;
    pe_state_e        w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic [CW-1:0]    w_code;
    logic             w_none;
    logic             w_onehot;
    logic             w_fire;

    prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
        .i_vec  (r_pending),
        .o_code (w_code),
        .o_none (w_none)
    );

    // Exactly one bit left means the current beat is the final one.
    assign w_onehot = (r_pending != '0) && ((r_pending & (r_pending - ONE)) == '0);

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == EMIT);
    assign out_code  = out_valid ? w_code : '0;
    assign out_none  = out_valid & w_none;
    assign out_last  = out_valid & (w_onehot | w_none);
    assign w_fire    = out_valid & out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_pending_nxt = in_data;
                    w_state_nxt   = EMIT;
                end
            end
            EMIT: begin
                if (w_fire) begin
                    w_pending_nxt = r_pending & ~(ONE << w_code);
                    if (out_last) w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Directed plus randomized bench for priority_encoder_seq with a beat-list
// reference model built from the set bits of each captured vector.
module tb_priority_encoder_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_code;
    logic         out_none;
    logic         out_last;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int code;
        bit none;
        bit last;
    } beat_t;

    beat_t exp_q[$];

    priority_encoder_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_none  (out_none),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: one beat per set bit, highest index first; zero -> one none beat.
    task automatic build_model(input logic [W-1:0] vec);
        beat_t b;
        exp_q.delete();
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                b.code = i; b.none = 1'b0; b.last = 1'b0;
                exp_q.push_back(b);
            end
        end
        if (exp_q.size() == 0) begin
            b.code = 0; b.none = 1'b1; b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            exp_q[exp_q.size() - 1].last = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = out_ready always 1, 1 = toggle 1,0,1,0..., 2 = random
    task automatic run_vec(input logic [W-1:0] vec, input int mode,
                           input bit hold, input logic [W-1:0] nxt);
        int idx;
        int cyc;
        bit rdy;
        build_model(vec);
        cyc = 0;
        while (!in_ready && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = vec;
        tick();
        if (hold) in_data = nxt;
        else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < 200) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_code",  32'(out_code),  32'(exp_q[idx].code));
            chk("out_none",  32'(out_none),  32'(exp_q[idx].none));
            chk("out_last",  32'(out_last),  32'(exp_q[idx].last));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom % 2);
            endcase
            out_ready = rdy;
            tick();
            if (rdy) idx++;
            cyc++;
        end
        chk("beats_done", 32'(idx), 32'(exp_q.size()));
        out_ready = 1'b0;
        chk("bubble_valid", 32'(out_valid), 32'd0);
        chk("ready_after",  32'(in_ready),  32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_code",  32'(out_code),  32'd0);
        chk("rst_none",  32'(out_none),  32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        run_vec(8'b1010_0100, 0, 1'b0, '0);
        run_vec(8'h00, 0, 1'b0, '0);
        run_vec(8'hFF, 1, 1'b0, '0);
        for (int i = 0; i < W; i++) run_vec(8'(1 << i), 0, 1'b0, '0);

        // Reset in the middle of an emission drops the remaining beats.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        chk("r3c_code5", 32'(out_code), 32'd5);
        out_ready = 1'b1;
        tick();
        chk("r3c_code4", 32'(out_code), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("r3c_valid", 32'(out_valid), 32'd0);
        chk("r3c_ready", 32'(in_ready),  32'd1);
        chk("r3c_code",  32'(out_code),  32'd0);
        chk("r3c_last",  32'(out_last),  32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("r3c_quiet", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        // New vector held on the input while the previous one is still emitting.
        run_vec(8'b0110_0000, 0, 1'b1, 8'h81);
        run_vec(8'h81, 0, 1'b0, '0);

        for (int n = 0; n < 25; n++) run_vec(8'($urandom), 2, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "timeout");
    end

endmodule
